page_tbl_xlate: RTL and testbench
=================================

# page_tbl_xlate

Pipelined address-translation stage that sits directly downstream of the 16-bit × 32-entry page table. It owns the table's read port: it accepts a (VID, logical offset) request, looks up that VID's entry, checks the offset against the entry's length, and emits a physical stateful-memory address or a fault. Write-port programming of the table stays with the control path and is outside this block.

## Interface
- `ADDR_BITS`, 5: VID width; also the page-table address width.
- `DATA_BITS`, 16: page-table entry width; entry layout is {base[15:8], len[7:0]}.
- `OFF_BITS`, 8: logical offset width and physical address width.
- `clk`  in  1  sole clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_vid`  in  ADDR_BITS  table index.
- `req_off`  in  OFF_BITS  logical offset.
- `tbl_addrb`  out  ADDR_BITS  page-table read address.
- `tbl_enb`  out  1  page-table read enable; must be high only on request acceptance.
- `tbl_doutb`  in  DATA_BITS  table read data, valid one cycle after `tbl_enb`, held while `tbl_enb` is low.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  result consumed when `rsp_valid && rsp_ready`.
- `rsp_addr`  out  OFF_BITS  physical address; 0 when `rsp_fault` is set.
- `rsp_fault`  out  1  the offset is out of range for the VID.
- `fault_cnt`  out  16  saturating count of faulted responses.
- `fault_clr`  in  1  synchronous clear of `fault_cnt`.

## Operation
- Two-stage pipeline: S1 (table read in flight) and S2 (output register).
- On acceptance, `tbl_addrb = req_vid` and `tbl_enb = 1` combinationally. S1 captures `req_off` and sets `s1_valid`.
- S2 load condition: `s1_valid && (!rsp_valid || rsp_ready)`. It computes the following from `tbl_doutb`:
  - `base = tbl_doutb[15:8]`, `len = tbl_doutb[7:0]`.
  - `sum` is a (OFF_BITS+1)-bit value equal to `base + off`.
  - Fault when `off >= len` or `sum[OFF_BITS]` is 1 (overflow).
  - On fault, `rsp_addr = 0`; otherwise `rsp_addr = sum[OFF_BITS-1:0]`.
- `req_ready = !s1_valid || (!rsp_valid || rsp_ready)`. S1 can therefore accept a new request in the same cycle its contents move to S2.
- `s1_valid` clears when S1 moves to S2 with no new request accepted.
- `rsp_valid` clears on a handshake when S1 is not loading S2 in that cycle.
- `fault_cnt` increments on each faulted `rsp_valid && rsp_ready` handshake. It saturates at 0xFFFF.
- `fault_clr` has priority: when it coincides with a fault handshake, the result is 0.
- `len = 0` means every offset faults (an unprogrammed entry).

## Timing
- Latency: request accepted in cycle N produces `rsp_valid` in cycle N+2 if the output is free.
- Throughput: one response per cycle while `rsp_ready` stays high.
- Under backpressure the pipeline holds 2 requests. `req_ready` drops only when S1 and S2 are both full and `rsp_ready` is low.
- While stalled, `tbl_enb` stays 0, so the held `tbl_doutb` remains valid for S1.
- `rsp_*` is stable while `rsp_valid && !rsp_ready`.
- Reset values: `s1_valid = 0`, `rsp_valid = 0`, `rsp_addr = 0`, `rsp_fault = 0`, `fault_cnt = 0`.
- `req_ready` is 1 out of reset. `tbl_enb` is 0 out of reset because it is gated by acceptance.
- Reset mid-operation drops all in-flight requests and issues no response for them.
- A table write to a VID while a read of that VID is in flight: the old or new entry is returned per the RAM's read-during-write behaviour. The control path must quiesce before reprogramming.

## Structure
- Shared package: entry field offsets (`PT_BASE_MSB/LSB`, `PT_LEN_MSB/LSB`) and the fault-counter width. The same constants are used by the control-path writer.
- One natural sub-module, `pt_xlate_calc`: the combinational bounds check and add, producing `{fault, addr}`.
- The handshake and pipeline registers stay in the top module.

## Test plan
- Entry VID 3 = 0x2010, request (3, 0x05) -> `rsp_addr = 0x25`, `rsp_fault = 0`, exactly 2 cycles after acceptance.
- Same entry, request (3, 0x10) -> `rsp_fault = 1`, `rsp_addr = 0`, `fault_cnt = 1`.
- Entry VID 7 = 0xF0FF, request (7, 0x20) -> overflow fault. Request (7, 0x0F) -> `rsp_addr = 0xFF` with no fault.
- Back-to-back 32 requests (VIDs 0..31) with `rsp_ready` held high -> 32 consecutive `rsp_valid` cycles with in-order, correct addresses.
- `rsp_ready` low for 5 cycles mid-stream -> `req_ready` drops after 2 accepted requests, `tbl_enb` stays 0, outputs are stable, and there is no loss or duplication after release.
- `aresetn` pulsed with both stages full -> no response emitted, `fault_cnt = 0`, `req_ready = 1`. Also force `fault_cnt` to 0xFFFF and issue another fault -> it stays at 0xFFFF. `fault_clr` coinciding with a fault handshake -> 0.

Source files
------------

// File: rtl/page_tbl_xlate_pkg.sv
// Shared constants for the page-table translation path.
// Page-table entry layout is {base[15:8], len[7:0]}. The control-path
// writer packs entries with these same field positions.
// The fault counter width is also defined here.
package page_tbl_xlate_pkg;

  localparam int PT_BASE_MSB = 15;
  localparam int PT_BASE_LSB = 8;
  localparam int PT_LEN_MSB  = 7;
  localparam int PT_LEN_LSB  = 0;

  localparam int                     FAULT_CNT_W   = 16;
  localparam logic [FAULT_CNT_W-1:0] FAULT_CNT_MAX = '1;

endpackage : page_tbl_xlate_pkg

// File: rtl/page_tbl_xlate_calc.sv
// pt_xlate_calc: combinational bounds check and base+offset add.
// Ports:
//   entry_i  page-table entry {base, len}
//   off_i    logical offset
//   fault_o  offset out of range (off >= len) or base+off overflowed
//   addr_o   physical address; forced to 0 on fault
module pt_xlate_calc
  import page_tbl_xlate_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int OFF_BITS  = 8
) (
  input  logic [DATA_BITS-1:0] entry_i,
  input  logic [OFF_BITS-1:0]  off_i,
  output logic                 fault_o,
  output logic [OFF_BITS-1:0]  addr_o
);

  logic [OFF_BITS-1:0] base;
  logic [OFF_BITS-1:0] len;
  logic [OFF_BITS:0]   sum;

  always_comb begin
    base    = entry_i[PT_BASE_MSB:PT_BASE_LSB];
    len     = entry_i[PT_LEN_MSB:PT_LEN_LSB];
    // Extra carry bit catches wrap-around past the top of the memory.
    sum     = {1'b0, base} + {1'b0, off_i};
    // len == 0 makes every offset fault, which covers unprogrammed entries.
    fault_o = (off_i >= len) || sum[OFF_BITS];
    addr_o  = fault_o ? '0 : sum[OFF_BITS-1:0];
  end

endmodule : pt_xlate_calc

// File: rtl/page_tbl_xlate.sv
// page_tbl_xlate: two-stage address-translation pipeline in front of the
// 32-entry page table. The block owns the table's read port.
//   S1: table read in flight (holds the logical offset)
//   S2: output register (rsp_*)
// Ports:
//   clk, aresetn               clock and async active-low reset
//   req_valid/ready/vid/off    request handshake (VID, logical offset)
//   tbl_addrb/enb/doutb        page-table read port (1-cycle read latency)
//   rsp_valid/ready/addr/fault response handshake
//   fault_cnt, fault_clr       saturating faulted-response counter, sync clear
module page_tbl_xlate
  import page_tbl_xlate_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 16,
  parameter int OFF_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_BITS-1:0]   req_vid,
  input  logic [OFF_BITS-1:0]    req_off,
  output logic [ADDR_BITS-1:0]   tbl_addrb,
  output logic                   tbl_enb,
  input  logic [DATA_BITS-1:0]   tbl_doutb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OFF_BITS-1:0]    rsp_addr,
  output logic                   rsp_fault,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  input  logic                   fault_clr
);

  logic                   s1_valid_q, s1_valid_d;
  logic [OFF_BITS-1:0]    s1_off_q, s1_off_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [OFF_BITS-1:0]    rsp_addr_q, rsp_addr_d;
  logic                   rsp_fault_q, rsp_fault_d;
  logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  logic                   s2_free;
  logic                   s2_load;
  logic                   accept;
  logic                   rsp_hs;
  logic                   calc_fault;
  logic [OFF_BITS-1:0]    calc_addr;

  // tbl_doutb is held by the RAM while tbl_enb is low, so S1 can read it
  // directly for as long as S1 is stalled.
  pt_xlate_calc #(
    .DATA_BITS (DATA_BITS),
    .OFF_BITS  (OFF_BITS)
  ) u_calc (
    .entry_i (tbl_doutb),
    .off_i   (s1_off_q),
    .fault_o (calc_fault),
    .addr_o  (calc_addr)
  );

  always_comb begin
    // NOTE: every signal is given a default first so no path can infer a latch.
    s1_valid_d  = s1_valid_q;
    s1_off_d    = s1_off_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;
    fault_cnt_d = fault_cnt_q;

    s2_free   = !rsp_valid_q || rsp_ready;
    s2_load   = s1_valid_q && s2_free;
    // S1 can refill in the same cycle its contents move on to S2.
    req_ready = !s1_valid_q || s2_free;
    accept    = req_valid && req_ready;
    rsp_hs    = rsp_valid_q && rsp_ready;

    // The read is issued only on acceptance. During a stall the RAM output
    // therefore keeps the entry S1 is waiting on.
    tbl_enb   = accept;
    tbl_addrb = req_vid;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_off_d   = req_off;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = calc_addr;
      rsp_fault_d = calc_fault;
    end else if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end

    // The clear wins over a coincident faulted handshake.
    if (fault_clr) begin
      fault_cnt_d = '0;
    end else if (rsp_hs && rsp_fault_q && (fault_cnt_q != FAULT_CNT_MAX)) begin
      fault_cnt_d = fault_cnt_q + FAULT_CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples its pre-edge value. All of them are reset, because a reset must
  // drop any in-flight work.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q  <= 1'b0;
      s1_off_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_fault_q <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_off_q    <= s1_off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_fault = rsp_fault_q;
  assign fault_cnt = fault_cnt_q;

endmodule : page_tbl_xlate

// File: tb/tb_page_tbl_xlate.sv
// Self-checking bench for page_tbl_xlate. The bench models the page-table
// RAM read port. The reference model applies the translation rules with
// plain arithmetic, and a queue keeps the responses in order.
module tb_page_tbl_xlate;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_vid = '0;
  logic [7:0]  req_off = '0;
  logic [4:0]  tbl_addrb;
  logic        tbl_enb;
  logic [15:0] tbl_doutb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_addr;
  logic        rsp_fault;
  logic [15:0] fault_cnt;
  logic        fault_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] tbl [32];
  logic [8:0]  exp_q [$];
  logic [15:0] exp_cnt = '0;

  // Values sampled by the most recent step() call.
  logic        s_acc, s_hs, s_rv, s_rdy, s_enb, s_fault, s_exp_ok;
  logic [7:0]  s_addr;
  logic [15:0] s_cnt;
  logic        e_fault;
  logic [7:0]  e_addr;
  logic [15:0] e_cnt;

  page_tbl_xlate dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vid   (req_vid),
    .req_off   (req_off),
    .tbl_addrb (tbl_addrb),
    .tbl_enb   (tbl_enb),
    .tbl_doutb (tbl_doutb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .fault_cnt (fault_cnt),
    .fault_clr (fault_clr)
  );

  always #5 clk = ~clk;

  // Page-table read port: one-cycle latency, output held when not enabled.
  always @(posedge clk) if (tbl_enb) tbl_doutb <= tbl[tbl_addrb];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference translation computed from the entry rules.
  function automatic logic [8:0] ref_xlate(input logic [15:0] entry, input logic [7:0] off);
    int base, len, sum;
    logic f;
    base = int'(entry[15:8]);
    len  = int'(entry[7:0]);
    sum  = base + int'(off);
    f    = (int'(off) >= len) || (sum > 255);
    return {f, f ? 8'h00 : 8'(sum % 256)};
  endfunction

  // Drives one cycle's inputs at the falling edge, samples outputs, and
  // advances the scoreboard and counter model. It performs no comparisons.
  task automatic step(input logic v, input logic [4:0] vid, input logic [7:0] off,
                      input logic rr, input logic clr);
    @(negedge clk);
    req_valid = v; req_vid = vid; req_off = off; rsp_ready = rr; fault_clr = clr;
    #1;
    s_acc = req_valid && req_ready;
    s_hs  = rsp_valid && rsp_ready;
    s_rv = rsp_valid; s_rdy = req_ready; s_enb = tbl_enb;
    s_addr = rsp_addr; s_fault = rsp_fault; s_cnt = fault_cnt;
    e_cnt = exp_cnt;
    s_exp_ok = 1'b1;
    if (s_hs) begin
      if (exp_q.size() > 0) {e_fault, e_addr} = exp_q.pop_front();
      else begin s_exp_ok = 1'b0; e_fault = 1'b0; e_addr = '0; end
    end
    if (s_acc) exp_q.push_back(ref_xlate(tbl[vid], off));
    if (clr) exp_cnt = '0;
    else if (s_hs && e_fault && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b exp 1", s_rdy); end
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", s_rv); end
    checks++; if (s_addr !== 8'h00) begin errors++; $display("FAIL reset_rsp_addr: got %h exp 00", s_addr); end
    checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault: got %b exp 0", s_fault); end
    checks++; if (s_cnt !== 16'h0000) begin errors++; $display("FAIL reset_fault_cnt: got %h exp 0000", s_cnt); end
    checks++; if (s_enb !== 1'b0) begin errors++; $display("FAIL reset_tbl_enb: got %b exp 0", s_enb); end
  endtask

  // One isolated request: checks acceptance, a latency of 2 cycles, the
  // result, and the fault counter after the handshake.
  task automatic test_single(input logic [4:0] vid, input logic [7:0] off);
    int lat;
    step(1'b1, vid, off, 1'b1, 1'b0);
    checks++; if (s_acc !== 1'b1) begin errors++; $display("FAIL single_accept vid=%0d: got %b exp 1", vid, s_acc); end
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
      if (s_rv) begin
        lat = i;
        checks++; if (!s_exp_ok) begin errors++; $display("FAIL single_extra_rsp vid=%0d", vid); end
        checks++; if (s_addr !== e_addr || s_fault !== e_fault) begin
          errors++; $display("FAIL single_rsp vid=%0d off=%h: got addr=%h fault=%b exp addr=%h fault=%b",
                             vid, off, s_addr, s_fault, e_addr, e_fault);
        end
      end
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL single_latency vid=%0d: got %0d exp 2 (0 = timeout)", vid, lat); end
    step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    checks++; if (s_cnt !== e_cnt) begin errors++; $display("FAIL single_fault_cnt: got %h exp %h", s_cnt, e_cnt); end
  endtask

  task automatic test_directed();
    tbl[3] = 16'h2010;
    tbl[7] = 16'hF0FF;
    test_single(5'd3, 8'h05);   // 0x20 + 0x05 = 0x25
    test_single(5'd3, 8'h10);   // off == len -> fault
    test_single(5'd7, 8'h20);   // 0xF0 + 0x20 overflows -> fault
    test_single(5'd7, 8'h0F);   // 0xFF, no fault
  endtask

  task automatic test_back_to_back();
    int idx, resp, run, max_run;
    for (int i = 0; i < 32; i++)
      tbl[i] = (i % 8 == 0) ? {8'($urandom), 8'h00} : 16'($urandom);
    idx = 0; resp = 0; run = 0; max_run = 0;
    for (int c = 0; c < 100 && resp < 32; c++) begin
      step(idx < 32, 5'(idx), 8'($urandom), 1'b1, 1'b0);
      if (s_acc) idx++;
      run = s_rv ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (s_hs) begin
        resp++;
        checks++; if (!s_exp_ok || s_addr !== e_addr || s_fault !== e_fault) begin
          errors++; $display("FAIL b2b_rsp #%0d: got addr=%h fault=%b exp addr=%h fault=%b sb_ok=%b",
                             resp, s_addr, s_fault, e_addr, e_fault, s_exp_ok);
        end
      end
    end
    checks++; if (resp != 32) begin errors++; $display("FAIL b2b_count: got %0d exp 32", resp); end
    checks++; if (max_run != 32) begin errors++; $display("FAIL b2b_consecutive: got %0d exp 32", max_run); end
    step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    checks++; if (s_cnt !== e_cnt) begin errors++; $display("FAIL b2b_fault_cnt: got %h exp %h", s_cnt, e_cnt); end
  endtask

  task automatic test_backpressure();
    int acc_stall, accepted, resp;
    logic        held;
    logic [7:0]  h_addr;
    logic        h_fault;
    logic [4:0]  vid;
    logic [7:0]  off;
    acc_stall = 0; accepted = 0; resp = 0; held = 1'b0; h_addr = '0; h_fault = 1'b0;
    vid = 5'($urandom); off = 8'($urandom);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, vid, off, 1'b0, 1'b0);
      if (s_acc) begin acc_stall++; accepted++; vid = 5'($urandom); off = 8'($urandom); end
      if (!s_rdy) begin
        checks++; if (s_enb !== 1'b0) begin errors++; $display("FAIL stall_tbl_enb cyc=%0d: got %b exp 0", c, s_enb); end
      end
      if (s_rv && held) begin
        checks++; if (s_addr !== h_addr || s_fault !== h_fault) begin
          errors++; $display("FAIL stall_stable cyc=%0d: got %h/%b exp %h/%b", c, s_addr, s_fault, h_addr, h_fault);
        end
      end
      if (s_rv && !held) begin held = 1'b1; h_addr = s_addr; h_fault = s_fault; end
    end
    checks++; if (acc_stall != 2) begin errors++; $display("FAIL stall_accepts: got %0d exp 2", acc_stall); end
    for (int c = 0; c < 40 && (accepted < 8 || exp_q.size() > 0); c++) begin
      step(accepted < 8, vid, off, 1'b1, 1'b0);
      if (s_acc) begin accepted++; vid = 5'($urandom); off = 8'($urandom); end
      if (s_hs) begin
        resp++;
        checks++; if (!s_exp_ok || s_addr !== e_addr || s_fault !== e_fault) begin
          errors++; $display("FAIL bp_rsp #%0d: got addr=%h fault=%b exp addr=%h fault=%b sb_ok=%b",
                             resp, s_addr, s_fault, e_addr, e_fault, s_exp_ok);
        end
      end
    end
    step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    checks++; if (resp != accepted || s_rv !== 1'b0) begin
      errors++; $display("FAIL bp_count: got %0d rsp (valid=%b) exp %0d", resp, s_rv, accepted);
    end
    checks++; if (s_cnt !== e_cnt) begin errors++; $display("FAIL bp_fault_cnt: got %h exp %h", s_cnt, e_cnt); end
  endtask

  task automatic test_reset_midflight();
    tbl[3] = 16'h2010;
    step(1'b1, 5'd3, 8'h01, 1'b0, 1'b0);
    step(1'b1, 5'd3, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
      checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL rst_no_rsp cyc=%0d: got %b exp 0", c, s_rv); end
    end
    checks++; if (s_cnt !== 16'h0000) begin errors++; $display("FAIL rst_fault_cnt: got %h exp 0000", s_cnt); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b exp 1", s_rdy); end
  endtask

  task automatic test_saturate_and_clear();
    logic got;
    tbl[3] = 16'h2010;
    @(negedge clk);
    force dut.fault_cnt_q = 16'hFFFF;
    #1;
    release dut.fault_cnt_q;
    exp_cnt = 16'hFFFF;
    step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    checks++; if (s_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preset: got %h exp ffff", s_cnt); end
    test_single(5'd3, 8'h10);   // faulting request while saturated
    // A faulted response held under backpressure, then consumed together with fault_clr.
    step(1'b1, 5'd3, 8'h10, 1'b0, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
      got = s_rv;
    end
    checks++; if (!got) begin errors++; $display("FAIL clr_wait: got no rsp_valid exp 1"); end
    step(1'b0, 5'd0, 8'd0, 1'b1, 1'b1);
    checks++; if (s_hs !== 1'b1 || s_fault !== e_fault || s_fault !== 1'b1) begin
      errors++; $display("FAIL clr_hs: got hs=%b fault=%b exp hs=1 fault=1", s_hs, s_fault);
    end
    step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0);
    checks++; if (s_cnt !== e_cnt) begin errors++; $display("FAIL clr_priority: got %h exp %h", s_cnt, e_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tbl[i] = '0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_saturate_and_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_page_tbl_xlate
